// File: rtl/pool_pkg.sv
// pool_pkg: pixel width, controller states and the signed pairwise-max rule
// shared by the conv and pool blocks.
package pool_pkg;

   localparam int DATA_W = 21;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   typedef logic signed [DATA_W-1:0] pix_t;

   // Native signed compare of equal-width operands is exact; no subtraction, so no overflow.
   function automatic pix_t max2(input pix_t a, input pix_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_linebuf.sv
// pool_linebuf: half-width line buffer holding even-row horizontal pair maxima,
// synchronous write, asynchronous read, one shared column-pair index.
module pool_linebuf
   import pool_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = 5
)(
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] idx,
   input  pix_t          wr_data,
   output pix_t          rd_data
);

   pix_t mem [DEPTH];

   always_ff @(posedge clk)
      if (we) mem[idx] <= wr_data;

   assign rd_data = mem[idx];

endmodule

// File: rtl/pool2x2_ctrl.sv
// pool2x2_ctrl: streaming 2x2/stride-2 signed max-pool over a raster-order
// feature map of runtime-configured size, one pooled value per window out.
module pool2x2_ctrl
   import pool_pkg::*;
#(
   parameter int MAX_W = 64,
   parameter int MAX_H = 64,
   localparam int WW = $clog2(MAX_W + 1),
   localparam int HW = $clog2(MAX_H + 1),
   localparam int CW = $clog2(MAX_W),
   localparam int RW = $clog2(MAX_H)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [WW-1:0]     cfg_w,
   input  logic [HW-1:0]     cfg_h,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);

   state_t        state;
   logic [WW-1:0] w_q;
   logic [HW-1:0] h_q;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   pix_t          hold, h_max, lb_rd;
   logic          fire_in, fire_out, last_col, last_row, cfg_ok;

   assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
   assign fire_in  = in_valid && in_ready;
   assign fire_out = out_valid && out_ready;
   assign last_col = WW'(col) == w_q - WW'(1);
   assign last_row = HW'(row) == h_q - HW'(1);
   assign cfg_ok   = !cfg_w[0] && !cfg_h[0] && cfg_w != '0 && cfg_h != '0 &&
                     cfg_w <= WW'(MAX_W) && cfg_h <= HW'(MAX_H);
   assign h_max    = max2(hold, in_data);
   assign busy     = (state == S_RUN) || (state == S_DRAIN);
   assign done     = state == S_DONE;

   pool_linebuf #(.DEPTH(MAX_W / 2), .AW(CW - 1)) u_linebuf (
      .clk     (clk),
      .we      (fire_in && col[0] && !row[0]),
      .idx     (col[CW-1:1]),
      .wr_data (h_max),
      .rd_data (lb_rd)
   );

   // An output handshake and a fresh odd/odd load in the same cycle: the load wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         w_q       <= '0;
         h_q       <= '0;
         col       <= '0;
         row       <= '0;
         hold      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         cfg_err   <= 1'b0;
      end else begin
         if (fire_out) out_valid <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               cfg_err <= !cfg_ok;
               if (cfg_ok) begin
                  state <= S_RUN;
                  w_q   <= cfg_w;
                  h_q   <= cfg_h;
                  col   <= '0;
                  row   <= '0;
               end
            end
            S_RUN: if (fire_in) begin
               if (!col[0]) hold <= in_data;
               else if (row[0]) begin
                  out_data  <= max2(h_max, lb_rd);
                  out_valid <= 1'b1;
               end
               col <= last_col ? '0 : col + 1'b1;
               row <= last_col ? row + 1'b1 : row;
               if (last_col && last_row) state <= S_DRAIN;
            end
            S_DRAIN: if (fire_out) state <= S_DONE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/pool2x2_ctrl.md
# pool2x2_ctrl

Streaming 2x2/stride-2 max-pool controller for the CNN datapath. It accepts conv results in raster order for a runtime-configured feature map and builds horizontal pair maxima with the shared signed pairwise-max rule. Even-row partial maxima go into a half-width line buffer; one pooled value per 2x2 window is emitted on a valid/ready output. The block sits between the conv accumulator output and the pooled-feature write-back.

## Interface
- DATA_W, 21, width of every pixel value (two's complement)
- MAX_W, 64, maximum feature-map width in pixels (even)
- MAX_H, 64, maximum feature-map height in pixels (even)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle frame start; sampled only in IDLE
- cfg_w  in  $clog2(MAX_W+1)  frame width, latched on accepted start
- cfg_h  in  $clog2(MAX_H+1)  frame height, latched on accepted start
- in_valid  in  1  input pixel valid
- in_ready  out  1  input pixel accepted when in_valid && in_ready
- in_data  in  DATA_W  input pixel
- out_valid  out  1  pooled value valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  DATA_W  pooled value
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse after the last pooled value is accepted
- cfg_err  out  1  sticky; set by a rejected start, cleared by the next accepted start

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start when cfg_w and cfg_h are even, 2..MAX_W and 2..MAX_H. Any other start sets cfg_err and leaves the FSM in IDLE.
- Counters col (0..W-1) and row (0..H-1) advance on every input handshake. col wraps to 0 at W-1, then row increments.
- Even col: pixel stored in hold register.
- Odd col: h = max(hold, in_data).
  - Even row: linebuf[col>>1] <= h.
  - Odd row: out_data <= max(h, linebuf[col>>1]), out_valid <= 1.
- max is a full signed compare with no overflow: compare sign-extended operands, not the sign of a truncated subtraction. Ties return either operand; the value is identical.
- RUN -> DRAIN on the handshake of pixel (H-1, W-1).
- DRAIN -> DONE on the output handshake. DONE -> IDLE after one cycle.
- Output count per frame is W*H/4, in raster order of the pooled map.
- start outside IDLE is ignored; it does not set cfg_err.
- Line buffer contents are not cleared between frames. Every entry is written on an even row before it is read.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, cfg_err=0. The FSM resets to IDLE and the counters to 0.
- in_ready = (state==RUN) && (!out_valid || out_ready). This is combinational and carries no dependence on in_valid.
- Latency: out_valid rises the cycle after the odd-row odd-col input handshake.
- out_valid/out_data hold stable until handshaken. A same-cycle handshake and new load replaces the value with no bubble.
- Full throughput is 1 pixel/cycle while out_ready=1.
- done rises the cycle after the final output handshake; busy falls in that same cycle.
- The earliest next accepted start is the cycle done is high+1 (back in IDLE).
- Asynchronous reset mid-frame aborts the frame: all outputs return to their reset values immediately, with no done pulse.

## Structure
- Shared package pool_pkg holds DATA_W, the state enum, and the signed max2 function. The conv and pool blocks use the same function.
- One sub-module, pool_linebuf: MAX_W/2 x DATA_W register array with one synchronous write port and one asynchronous read port, indexed by col>>1.
- The controller contains the FSM, counters, hold register and output register.

## Test plan
- 4x2 frame, start with cfg_w=4, cfg_h=2; inputs 1,5,2,3 / 4,0,9,-1; out_ready=1 -> outputs 5 then 9, then a done pulse. out_valid rises 1 cycle after each odd-row odd-col beat.
- Signed extremes, 2x2 frame; inputs -1048576, 1048575, -1, 0 -> output 1048575. Then inputs -5, -3, -7, -4 -> output -3.
- Backpressure, 4x4 frame of values 0..15; out_ready low for 3 cycles around each output -> outputs 5, 7, 13, 15 unchanged and in order. in_ready is low whenever out_valid && !out_ready.
- Config error: start with cfg_w=3 -> cfg_err=1, state stays IDLE, in_ready=0. Next start with 2x2 -> cfg_err=0 and the frame runs normally.
- Back-to-back frames: 2x2 frame, then start the cycle after done -> the second frame's output is correct and independent of the first frame's linebuf data.
- Reset mid-frame: assert rst_n=0 after 5 pixels of a 4x4 frame -> outputs go to their reset values at once. A following 2x2 frame produces the correct single output.
